// File: rtl/vga_timing_pkg.sv
// Shared encodings and default 1024x768 timing for the VGA timing controller.
// Both axes use the same region decode, so it lives here.
package vga_timing_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_ACTIVE = 1024;
   localparam int DEF_H_FRONT  = 24;
   localparam int DEF_H_SYNC   = 136;
   localparam int DEF_H_BACK   = 160;
   localparam int DEF_V_ACTIVE = 768;
   localparam int DEF_V_FRONT  = 3;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BACK   = 29;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_RUN          = 2'd1,
      ST_STOP_PENDING = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RG_ACTIVE = 2'd0,
      RG_FRONT  = 2'd1,
      RG_SYNC   = 2'd2,
      RG_BACK   = 2'd3
   } region_t;

   // Regions are laid out ACTIVE, FRONT, SYNC, BACK along each axis.
   function automatic region_t region_of(input logic [CNT_W-1:0] cnt,
                                         input int active, input int front, input int sync);
      region_t rg;
      if (cnt < CNT_W'(active))
         rg = RG_ACTIVE;
      else if (cnt < CNT_W'(active + front))
         rg = RG_FRONT;
      else if (cnt < CNT_W'(active + front + sync))
         rg = RG_SYNC;
      else
         rg = RG_BACK;
      return rg;
   endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: wrapping counter plus region decode of the value it is about
// to take, so the parent can register outputs aligned with the counter.
module vga_timing_axis
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FRONT  = DEF_H_FRONT,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BACK   = DEF_H_BACK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt_nxt,
   output region_t          region_nxt,
   output logic             wrap
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] cnt;

   assign wrap = (cnt == LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = '0;
      else if (inc)
         cnt_nxt = wrap ? '0 : cnt + 1'b1;
   end

   assign region_nxt = region_of(cnt_nxt, ACTIVE, FRONT, SYNC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA sync/blanking generator with graceful stop: dropping enable lets the
// current frame finish before returning to IDLE.
module vga_timing_controller
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE        = DEF_H_ACTIVE,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_ACTIVE        = DEF_V_ACTIVE,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic        control_clock,
   input  logic        reset,
   input  logic        enable,
   output logic        h_sync,
   output logic        v_sync,
   output logic        active_video,
   output logic [10:0] pixel_x,
   output logic [10:0] pixel_y,
   output logic        line_start,
   output logic        frame_start,
   output logic        busy
);

   localparam logic SYNC_ON  = !SYNC_ACTIVE_LOW;
   localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

   state_t           state;
   logic [CNT_W-1:0] h_nxt, v_nxt;
   region_t          h_rg, v_rg;
   logic             h_wrap, v_wrap;
   logic             frame_end, go_idle, live_nxt, cnt_clear, vis_nxt;

   assign frame_end = h_wrap && v_wrap;
   assign go_idle   = (state == ST_STOP_PENDING) && frame_end;
   // live_nxt: the controller will be outside IDLE in the coming cycle.
   assign live_nxt  = (state == ST_IDLE) ? enable : !go_idle;
   // Counters sit at 0 through IDLE and the first RUN cycle.
   assign cnt_clear = (state == ST_IDLE) || go_idle;
   assign vis_nxt   = live_nxt && (h_rg == RG_ACTIVE) && (v_rg == RG_ACTIVE);

   vga_timing_axis #(
      .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_axis (
      .clk        (control_clock),
      .rst        (reset),
      .clear      (cnt_clear),
      .inc        (1'b1),
      .cnt_nxt    (h_nxt),
      .region_nxt (h_rg),
      .wrap       (h_wrap)
   );

   vga_timing_axis #(
      .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v_axis (
      .clk        (control_clock),
      .rst        (reset),
      .clear      (cnt_clear),
      .inc        (h_wrap),
      .cnt_nxt    (v_nxt),
      .region_nxt (v_rg),
      .wrap       (v_wrap)
   );

   always_ff @(posedge control_clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         h_sync       <= SYNC_OFF;
         v_sync       <= SYNC_OFF;
         active_video <= 1'b0;
         pixel_x      <= '0;
         pixel_y      <= '0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:         if (enable) state <= ST_RUN;
            ST_RUN:          if (!enable) state <= ST_STOP_PENDING;
            ST_STOP_PENDING: begin
               // End of frame wins over a late re-enable.
               if (frame_end)   state <= ST_IDLE;
               else if (enable) state <= ST_RUN;
            end
            default:         state <= ST_IDLE;
         endcase
         busy         <= live_nxt;
         h_sync       <= (live_nxt && h_rg == RG_SYNC) ? SYNC_ON : SYNC_OFF;
         v_sync       <= (live_nxt && v_rg == RG_SYNC) ? SYNC_ON : SYNC_OFF;
         active_video <= vis_nxt;
         pixel_x      <= vis_nxt ? h_nxt : '0;
         pixel_y      <= vis_nxt ? v_nxt : '0;
         line_start   <= live_nxt && (h_nxt == '0);
         frame_start  <= live_nxt && (h_nxt == '0) && (v_nxt == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller on a shrunk 16x11 raster so that
// several whole frames fit in a short run.
module tb_vga_timing_controller;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;   // 16
   localparam int VT = VA + VF + VS + VB;   // 11
   localparam int FT = HT * VT;             // 176

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        h_sync, v_sync, active_video, line_start, frame_start, busy;
   logic [10:0] pixel_x, pixel_y;

   int checks = 0;
   int errors = 0;
   int t = 0;

   vga_timing_controller #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .control_clock (clk),
      .reset         (reset),
      .enable        (enable),
      .h_sync        (h_sync),
      .v_sync        (v_sync),
      .active_video  (active_video),
      .pixel_x       (pixel_x),
      .pixel_y       (pixel_y),
      .line_start    (line_start),
      .frame_start   (frame_start),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // {busy, h_sync, v_sync, active_video, line_start, frame_start, pixel_x, pixel_y}
   function automatic logic [27:0] obs();
      return {busy, h_sync, v_sync, active_video, line_start, frame_start, pixel_x, pixel_y};
   endfunction

   // Expected outputs at frame position p (clocks since frame_start), or idle.
   function automatic logic [27:0] exp_vec(input int p, input bit live);
      int hc, vc;
      logic av, hs, vs;
      logic [10:0] px, py;
      if (!live)
         return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};
      hc = p % HT;
      vc = p / HT;
      av = (hc < HA) && (vc < VA);
      hs = !((hc >= 10) && (hc < 13));
      vs = !((vc >= 7) && (vc < 9));
      px = av ? 11'(hc) : 11'd0;
      py = av ? 11'(vc) : 11'd0;
      return {1'b1, hs, vs, av, (hc == 0), (hc == 0 && vc == 0), px, py};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== exp_vec(0, 1'b0)) begin
         errors++;
         $display("FAIL reset_held got %h want %h", obs(), exp_vec(0, 1'b0));
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(0, 1'b0)) begin
            errors++;
            $display("FAIL idle_no_enable cyc=%0d got %h want %h", i, obs(), exp_vec(0, 1'b0));
         end
      end
   endtask

   // Two back-to-back frames: syncs, blanking, coordinates and pulse spacing.
   task automatic test_frame();
      enable = 1'b1;
      t = -1;
      for (int i = 0; i < 2 * FT; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(t % FT, 1'b1)) begin
            errors++;
            $display("FAIL frame t=%0d got %h want %h", t, obs(), exp_vec(t % FT, 1'b1));
         end
      end
   endtask

   // Drop and re-raise enable mid-frame: raster continues with no gap.
   task automatic test_reenable();
      for (int i = 0; i < FT + 20; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(t % FT, 1'b1)) begin
            errors++;
            $display("FAIL reenable t=%0d got %h want %h", t, obs(), exp_vec(t % FT, 1'b1));
         end
         if (t % FT == 2 * HT) enable = 1'b0;
         if (t % FT == 4 * HT) enable = 1'b1;
      end
   endtask

   // Drop enable on line 3: frame finishes, then IDLE right after the last pixel.
   task automatic test_stop();
      bit dropped = 1'b0;
      for (int i = 0; i < 2 * FT; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(t % FT, 1'b1)) begin
            errors++;
            $display("FAIL stop_drain t=%0d got %h want %h", t, obs(), exp_vec(t % FT, 1'b1));
         end
         if (!dropped && t % FT == 3 * HT) begin
            enable = 1'b0;
            dropped = 1'b1;
         end else if (dropped && t % FT == FT - 1) begin
            break;
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(0, 1'b0)) begin
            errors++;
            $display("FAIL stop_idle cyc=%0d got %h want %h", i, obs(), exp_vec(0, 1'b0));
         end
      end
   endtask

   // enable re-raised exactly at the final edge: one IDLE cycle, then a fresh frame.
   task automatic test_restart_priority();
      enable = 1'b1;
      t = -1;
      for (int i = 0; i < FT; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(t % FT, 1'b1)) begin
            errors++;
            $display("FAIL prio_run t=%0d got %h want %h", t, obs(), exp_vec(t % FT, 1'b1));
         end
         if (t == 3 * HT) enable = 1'b0;
         if (t == FT - 1) enable = 1'b1;
      end
      tick();
      checks++;
      if (obs() !== exp_vec(0, 1'b0)) begin
         errors++;
         $display("FAIL prio_idle got %h want %h", obs(), exp_vec(0, 1'b0));
      end
      t = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(t, 1'b1)) begin
            errors++;
            $display("FAIL prio_restart t=%0d got %h want %h", t, obs(), exp_vec(t, 1'b1));
         end
      end
   endtask

   // Async reset on line 5 clears outputs without waiting for a clock edge.
   task automatic test_reset_mid_frame();
      for (int i = 0; i < FT; i++) begin
         tick();
         if (t % FT == 5 * HT + 3) break;
      end
      checks++;
      if (obs() !== exp_vec(t % FT, 1'b1)) begin
         errors++;
         $display("FAIL pre_reset t=%0d got %h want %h", t, obs(), exp_vec(t % FT, 1'b1));
      end
      reset = 1'b1;
      enable = 1'b0;
      #1;
      checks++;
      if (obs() !== exp_vec(0, 1'b0)) begin
         errors++;
         $display("FAIL async_reset got %h want %h", obs(), exp_vec(0, 1'b0));
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (obs() !== exp_vec(0, 1'b0)) begin
         errors++;
         $display("FAIL post_reset_idle got %h want %h", obs(), exp_vec(0, 1'b0));
      end
      enable = 1'b1;
      t = -1;
      for (int i = 0; i < 2 * HT + 4; i++) begin
         tick();
         checks++;
         if (obs() !== exp_vec(t, 1'b1)) begin
            errors++;
            $display("FAIL post_reset_run t=%0d got %h want %h", t, obs(), exp_vec(t, 1'b1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_reenable();
      test_stop();
      test_restart_priority();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 24, horizontal front-porch clocks.
REQ-003 SHALL have parameter H_SYNC, default 136, horizontal sync-pulse clocks.
REQ-004 SHALL have parameter H_BACK, default 160, horizontal back-porch clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 3, vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 6, vertical sync-pulse lines.
REQ-008 SHALL have parameter V_BACK, default 29, vertical back-porch lines.
REQ-009 SHALL have parameter SYNC_ACTIVE_LOW, default 1, sync pulse polarity (1 = pulse drives 0).
REQ-010 SHALL have port control_clock  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-011 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-012 SHALL have port enable  input  1  run request, level-sensitive.
REQ-013 SHALL have ports h_sync, v_sync  output  1 each  sync pulses, polarity per SYNC_ACTIVE_LOW.
REQ-014 SHALL have port active_video  output  1  high while the current pixel is visible.
REQ-015 SHALL have ports pixel_x, pixel_y  output  11 each  visible coordinates; 0 outside active video.
REQ-016 SHALL have ports line_start, frame_start  output  1 each  single-cycle pulses.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL use 11-bit counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1); H_TOTAL = sum of the H_* parameters (1344), V_TOTAL = sum of the V_* parameters (806).
REQ-019 SHALL order the regions within each axis as ACTIVE, FRONT, SYNC, BACK; with defaults, h sync spans h_cnt 1048..1183 and v sync spans v_cnt 771..776.
REQ-020 SHALL have top states IDLE, RUN, STOP_PENDING.
REQ-021 IDLE SHALL hold both counters at 0, both syncs at the inactive level, and active_video, line_start and frame_start at 0.
REQ-022 In IDLE with enable=1 at a clock edge, the controller SHALL enter RUN; in the following cycle h_cnt=0, v_cnt=0 and frame_start=1.
REQ-023 In RUN, h_cnt SHALL increment every clock and wrap from H_TOTAL-1 to 0; v_cnt SHALL increment on that wrap and wrap from V_TOTAL-1 to 0.
REQ-024 line_start SHALL be 1 exactly when h_cnt=0 in RUN or STOP_PENDING; frame_start SHALL be 1 exactly when h_cnt=0 and v_cnt=0 in RUN or STOP_PENDING.
REQ-025 All outputs SHALL be registered and aligned with the counter values they describe, so that h_sync, active_video and pixel_x change in the same cycle as the counters (zero relative latency).
REQ-026 enable=0 in RUN SHALL move the controller to STOP_PENDING, and the current frame SHALL complete unchanged.
REQ-027 enable=1 in STOP_PENDING SHALL return the controller to RUN with no timing disturbance.
REQ-028 In STOP_PENDING at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, the controller SHALL enter IDLE in the next cycle instead of wrapping.
REQ-029 The end-of-frame check SHALL take priority: enable=1 sampled at that final edge SHALL still enter IDLE, and RUN SHALL restart one cycle later per REQ-022.

Reset
REQ-030 Reset SHALL force IDLE, counters 0, syncs inactive, and all other outputs 0, independent of the clock.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release the controller SHALL behave as from power-up.

Structure
REQ-032 Package vga_timing_pkg SHALL hold the state encoding, the axis-region encoding and the default 1024x768 timing constants.
REQ-033 Sub-module vga_timing_axis (counter, region decode, wrap flag) SHALL be instantiated twice, once for the horizontal axis and once for the vertical axis.

Verification
REQ-034 Reset release, enable=1 -> frame_start at the first RUN cycle; line_start period 1344 clocks; frame_start period 1344*806 = 1083264 clocks.
REQ-035 Running frame -> h_sync low for exactly 136 clocks starting at h_cnt=1048; v_sync low for exactly 6 lines starting at v_cnt=771.
REQ-036 Running frame -> active_video high for 1024 clocks per line on lines 0..767; pixel_x runs 0..1023; pixel_x=0 and pixel_y=0 elsewhere.
REQ-037 enable dropped at v_cnt=100 -> frame completes; IDLE (busy=0) in the cycle after h_cnt=1343, v_cnt=805.
REQ-038 enable dropped then reasserted before frame end -> no idle gap and frame_start spacing unchanged; reset pulse at v_cnt=400 -> all outputs return to reset values within the same cycle.
